// File: rtl/voice_phase_seq_pkg.sv
// Shared constants for the four-voice phase sequencer.
package voice_phase_seq_pkg;
  localparam int unsigned NUM_VOICES  = 4;
  localparam int unsigned VOICE_IDX_W = 2;
  localparam int unsigned DEF_M       = 12;
  localparam int unsigned DEF_N       = 16;
endpackage

// File: rtl/voice_phase_seq_tw_regfile.sv
// Tuning-word storage: one synchronous write port, one asynchronous read port.
module tw_regfile
  import voice_phase_seq_pkg::*;
#(
  parameter int unsigned N = DEF_N
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic [VOICE_IDX_W-1:0] waddr,
  input  logic [N-1:0]           wdata,
  input  logic [VOICE_IDX_W-1:0] raddr,
  output logic [N-1:0]           rdata
);

  logic [N-1:0] mem [NUM_VOICES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_VOICES); i++) mem[i] <= '0;
    end else if (wr) begin
      mem[waddr] <= wdata;
    end
  end

  // Read sees the pre-edge value, so a same-edge write lands in the next slot.
  assign rdata = mem[raddr];

endmodule

// File: rtl/voice_phase_seq.sv
// Time-multiplexed phase accumulator for four voices feeding a shared I-mux.
module voice_phase_seq
  import voice_phase_seq_pkg::*;
#(
  parameter int unsigned M = DEF_M,
  parameter int unsigned N = DEF_N
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   sync,
  input  logic                   tw_wr,
  input  logic [VOICE_IDX_W-1:0] tw_addr,
  input  logic [N-1:0]           tw_data,
  output logic [M-1:0]           phase_out,
  output logic [VOICE_IDX_W-1:0] sel,
  output logic                   valid,
  output logic                   frame_start
);

  logic [N-1:0]           acc [NUM_VOICES];
  logic [VOICE_IDX_W-1:0] v;
  logic [N-1:0]           tw_cur;
  logic [N-1:0]           acc_sum;

  tw_regfile #(.N(N)) u_tw_regfile (
    .clk   (clk),
    .rst   (rst),
    .wr    (tw_wr),
    .waddr (tw_addr),
    .wdata (tw_data),
    .raddr (v),
    .rdata (tw_cur)
  );

  // Modular add; the carry out is intentionally dropped.
  always_comb begin
    acc_sum = '0;
    acc_sum = acc[v] + tw_cur;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_VOICES); i++) acc[i] <= '0;
      v           <= '0;
      phase_out   <= '0;
      sel         <= '0;
      valid       <= 1'b0;
      frame_start <= 1'b0;
    end else if (sync) begin
      for (int i = 0; i < int'(NUM_VOICES); i++) acc[i] <= '0;
      v           <= '0;
      valid       <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      acc[v]      <= acc_sum;
      phase_out   <= acc_sum[N-1 -: M];
      sel         <= v;
      valid       <= 1'b1;
      frame_start <= (v == '0);
      v           <= v + VOICE_IDX_W'(1);
    end else begin
      valid       <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: doc/voice_phase_seq.md
VOICE_PHASE_SEQ -- requirements
Module: voice_phase_seq

Interface
REQ-001 Parameter M, default 12, phase output width fed to the voice I-mux.
REQ-002 Parameter N, default 16, accumulator and tuning-word width; N >= M.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset (clk, rst).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 en  input  1  advance enable; 0 = freeze sequencing.
REQ-007 sync  input  1  synchronous phase clear for all voices.
REQ-008 tw_wr  input  1  tuning-word write strobe.
REQ-009 tw_addr  input  2  voice index for the write.
REQ-010 tw_data  input  N  tuning-word value.
REQ-011 phase_out  output  M  phase of voice sel, i.e. acc[N-1:N-M].
REQ-012 sel  output  2  voice index paired with phase_out; drives the I-mux sel.
REQ-013 valid  output  1  phase_out/sel updated this cycle.
REQ-014 frame_start  output  1  high with valid when sel = 0.

Function
REQ-015 The block SHALL hold four N-bit tuning words tw[0..3] and four N-bit accumulators acc[0..3].
REQ-016 The voice counter v (2 bits) SHALL increment by 1 mod 4 on each clk edge with en=1, giving the order 0,1,2,3,0.
REQ-017 On an en=1 edge, acc[v] SHALL be updated to (acc[v] + tw[v]) mod 2^N, with silent wrap and no carry out.
REQ-018 On the same edge, phase_out SHALL load the top M bits of the new acc[v], sel SHALL load v, and valid SHALL be 1, for a latency of 1 cycle.
REQ-019 With en=0, v, acc, phase_out and sel SHALL hold, and valid and frame_start SHALL be 0.
REQ-020 tw_wr=1 SHALL write tw[tw_addr] <= tw_data on that edge, regardless of en.
REQ-021 A write to the voice being updated on the same edge SHALL NOT affect that update; the old tw is used and the new tw applies from that voice's next slot.
REQ-022 tw=0 SHALL hold the voice's phase constant, and the voice SHALL still appear in its slot with valid=1.
REQ-023 sync=1 SHALL clear all acc to 0 and v to 0 and set valid=0; it overrides en for that edge and leaves tw unchanged.
REQ-024 sync and tw_wr on the same edge SHALL both take effect.
REQ-025 frame_start SHALL equal valid AND (sel == 0) as registered outputs, not combinational from v.

Reset
REQ-026 On rst=1, tw[*], acc[*], v, phase_out, sel, valid and frame_start SHALL go to 0 immediately, without a clock edge.
REQ-027 After rst deasserts, the first en=1 edge SHALL process voice 0.
REQ-028 rst asserted mid-sequence SHALL discard all state; no partial frame is resumed.

Structure
REQ-029 The shared package SHALL hold NUM_VOICES=4, VOICE_IDX_W=2 and the default M and N constants.
REQ-030 The tuning-word storage (4 x N, one write port, one async read port indexed by v) SHALL be the sub-module tw_regfile.
REQ-031 Accumulators, counter and output registers SHALL live in voice_phase_seq; no other sub-modules.

Verification
REQ-032 Reset: assert rst mid-run without a clock -> all outputs 0 at once; first en cycle after release gives sel=0 and valid=1.
REQ-033 Sequencing: tw={1,2,3,4}, en=1 for 8 cycles -> sel 0,1,2,3,0,1,2,3, frame_start on cycles 1 and 5, acc={2,4,6,8} (N=16, phase_out=acc>>4).
REQ-034 Wrap: tw[0]=16'h8000 with 3 frames -> acc[0] goes 8000, 0000, 8000 and phase_out goes 12'h800, 12'h000, 12'h800.
REQ-035 Write collision: tw[2]=5, then write tw[2]=9 on the voice-2 slot edge -> that update adds 5 and the next voice-2 update adds 9.
REQ-036 en gap: deassert en for 3 cycles mid-frame -> valid=0 and outputs hold; sequence resumes at the next voice with no skip.
REQ-037 sync with tw_wr: assert both mid-frame -> all acc=0, next valid is sel=0 with phase = new tw top bits (if addressed voice 0).
